ad9361x2_tdd_sequencer: RTL and testbench
=========================================

Name: ad9361x2_tdd_sequencer

Overview:
- Frame-based TDD scheduler for the dual AD9361 datapath.
- Generates the shared ENSM control (enable, txnrx) for both transceivers from a cycle counter and programmed RX/TX windows.
- Aligns frame start across boards via the tdd_sync pin: master drives it, slave waits on it.
- Sits beside the dual-AD9361 PL wrapper. Its enable/txnrx outputs drive both chips' enable_0/enable_1 and txnrx_0/txnrx_1; its sync port maps onto tdd_sync_0.

Parameters:
- CNT_WIDTH, 24, width of frame counter and all window/length inputs.
- SYNC_PULSE_CYCLES, 4, master tdd_sync_o pulse width in cycles (>=1).

Ports:
- axi_aclk  input  1  block clock.
- axi_aresetn  input  1  asynchronous active-low reset.
- tdd_enable  input  1  1 = arm/run, 0 = stop.
- sync_slave  input  1  0 = master (drive sync), 1 = slave (wait for sync).
- frame_length  input  CNT_WIDTH  last counter value; period = frame_length+1.
- rx_on / rx_off  input  CNT_WIDTH each  RX window start/stop counts.
- tx_on / tx_off  input  CNT_WIDTH each  TX window start/stop counts.
- burst_frames  input  8  frames to run; 0 = continuous.
- tdd_sync_i  input  1  external sync, asynchronous.
- tdd_sync_o  output  1  sync pulse out (master only).
- tdd_sync_t  output  1  tristate control: 1 = pin is input, 0 = driven.
- enable  output  1  AD9361 ENABLE, both chips.
- txnrx  output  1  AD9361 TXNRX, both chips.
- frame_count  output  CNT_WIDTH  current counter value.
- frame_done  output  1  one-cycle pulse at the last count of each frame.
- busy  output  1  high in any state other than IDLE.
- cfg_error  output  1  sticky configuration error.

Behaviour:
- Reset (async, axi_aresetn=0):
  - state IDLE; counter 0; frames-done 0.
  - enable=0, txnrx=0, tdd_sync_o=0, tdd_sync_t=1, frame_done=0, busy=0, cfg_error=0.
  - Applies immediately mid-operation.
- tdd_sync_i path: 2-flop synchronizer plus an edge register; a rise produces a one-cycle sync_rise.
- FSM states: IDLE, ARM, RUN, DRAIN.
  - IDLE -> ARM when tdd_enable=1 and cfg_error=0.
    - On this transition, all config inputs are captured into shadow registers; later changes are ignored until the next arm.
    - Check at capture: if any of rx_on, rx_off, tx_on, tx_off exceeds frame_length, set cfg_error and stay in IDLE.
    - cfg_error clears only when tdd_enable=0.
  - ARM, master:
    - tdd_sync_t=0.
    - tdd_sync_o=1 for SYNC_PULSE_CYCLES cycles, then RUN; counter=0 on the first RUN cycle.
  - ARM, slave:
    - tdd_sync_t=1; wait for sync_rise, then RUN with counter=0 the next cycle.
    - Counter 0 appears on the 4th rising edge after tdd_sync_i rises, including the synchronizer stages.
  - ARM with tdd_enable=0: abort to IDLE next cycle.
  - RUN:
    - Counter +1 per cycle; wraps frame_length -> 0.
    - frame_done=1 on cycles where counter==frame_length.
    - Master pulses tdd_sync_o for SYNC_PULSE_CYCLES starting at each counter==0. Slave ignores sync in RUN.
  - RUN exit on a frame_done cycle:
    - frames-done counter reaches burst_frames (nonzero) -> IDLE, or
    - tdd_enable=0 -> IDLE.
    - Either way the frame always completes.
  - DRAIN: one cycle forcing enable=0, then IDLE. Entered from RUN on an IDLE exit; busy stays high.
- Window decode (combinational on counter; enable/txnrx registered, so 1 cycle latency from counter):
  - on<off: active when on<=counter<off.
  - on>off: wrap window, active when counter>=on or counter<off.
  - on==off: never active.
- Outputs:
  - enable = rx_act|tx_act.
  - txnrx = 1 when tx_act, 0 when rx_act only, and holds its last value when neither is active.
  - RX/TX overlap: TX wins (txnrx=1); no error.
- frame_length=0: period 1; frame_done is high every RUN cycle.
- tdd_sync_t=1 in IDLE and in slave mode at all times.

Test Plan:
- Master, frame_length=99, rx 10..40, tx 50..90, burst_frames=2:
  - tdd_sync_o high 4 cycles, then counter 0.
  - enable rises 1 cycle after count 10; txnrx 1 from count 50+1.
  - Exactly 2 frame_done pulses, then DRAIN, then IDLE; busy falls.
- Slave mode, tdd_sync_i rises at cycle T -> counter==0 at T+4; tdd_sync_t stays 1; no tdd_sync_o activity.
- Wrap windows: tx_on=90, tx_off=5, frame_length=99 -> enable/txnrx high for counts 90..99 and 0..4 (delayed 1 cycle).
  - rx_on=rx_off=20 -> no RX activity.
- tx_on=150, frame_length=99 -> cfg_error=1, busy stays 0; cfg_error clears when tdd_enable drops.
- Continuous run: tdd_enable dropped mid-frame at count 30 -> runs to count 99, then enable=0, then IDLE.
  - Shadow config changes during RUN have no effect.
- Assert axi_aresetn low during RUN at count 45 -> all outputs at reset values in the same cycle; after release the block stays IDLE until tdd_enable re-arms it.

Source files
------------

// File: rtl/ad9361x2_tdd_sequencer.sv
// Frame-based TDD sequencer for a dual-AD9361 datapath: produces the shared ENSM enable/txnrx
// from a frame counter and programmed RX/TX windows, and aligns frame start via tdd_sync.
module ad9361x2_tdd_sequencer #(
  parameter int CNT_WIDTH         = 24,
  parameter int SYNC_PULSE_CYCLES = 4
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 tdd_enable,
  input  logic                 sync_slave,
  input  logic [CNT_WIDTH-1:0] frame_length,
  input  logic [CNT_WIDTH-1:0] rx_on,
  input  logic [CNT_WIDTH-1:0] rx_off,
  input  logic [CNT_WIDTH-1:0] tx_on,
  input  logic [CNT_WIDTH-1:0] tx_off,
  input  logic [7:0]           burst_frames,
  input  logic                 tdd_sync_i,
  output logic                 tdd_sync_o,
  output logic                 tdd_sync_t,
  output logic                 enable,
  output logic                 txnrx,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 cfg_error,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int                   AW        = $clog2(SYNC_PULSE_CYCLES + 1);
  localparam logic [AW-1:0]        ARM_LAST  = AW'(SYNC_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LEN = CNT_WIDTH'(SYNC_PULSE_CYCLES);

  state_t               r_state;
  state_t               w_state_next;

  logic                 r_sync_meta;
  logic                 r_sync_s;
  logic                 r_sync_d;
  logic                 r_sync_rise;

  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_rx_on;
  logic [CNT_WIDTH-1:0] r_rx_off;
  logic [CNT_WIDTH-1:0] r_tx_on;
  logic [CNT_WIDTH-1:0] r_tx_off;
  logic [7:0]           r_burst;
  logic                 r_slave;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [7:0]           r_frames;
  logic [AW-1:0]        r_arm_cnt;
  logic                 r_first;
  logic                 r_enable;
  logic                 r_txnrx;
  logic                 r_cfg_error;

  logic                 w_cfg_bad;
  logic                 w_capture;
  logic                 w_last;
  logic                 w_burst_done;
  logic                 w_rx_act;
  logic                 w_tx_act;
  logic                 w_master_drive;

  // on<off: plain window; on>off: window wraps through the frame end; on==off: empty.
  function automatic logic win_act(input logic [CNT_WIDTH-1:0] on_cnt,
                                   input logic [CNT_WIDTH-1:0] off_cnt,
                                   input logic [CNT_WIDTH-1:0] cnt);
    logic act;
    act = 1'b0;
    if (on_cnt < off_cnt)      act = (cnt >= on_cnt) && (cnt < off_cnt);
    else if (on_cnt > off_cnt) act = (cnt >= on_cnt) || (cnt < off_cnt);
    return act;
  endfunction

  assign w_cfg_bad = (rx_on > frame_length) || (rx_off > frame_length) ||
                     (tx_on > frame_length) || (tx_off > frame_length);
  assign w_capture    = (r_state == S_IDLE) && tdd_enable && !r_cfg_error && !w_cfg_bad;
  assign w_last       = (r_cnt == r_len);
  assign w_burst_done = (r_burst != 8'd0) && ((r_frames + 8'd1) == r_burst);
  assign w_rx_act     = win_act(r_rx_on, r_rx_off, r_cnt);
  assign w_tx_act     = win_act(r_tx_on, r_tx_off, r_cnt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_state_next = S_ARM;
      end
      S_ARM: begin
        if (!tdd_enable)                          w_state_next = S_IDLE;
        else if (r_slave && r_sync_rise)          w_state_next = S_RUN;
        else if (!r_slave && r_arm_cnt == ARM_LAST) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last && (w_burst_done || !tdd_enable)) w_state_next = S_DRAIN;
      end
      S_DRAIN: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_sync_meta <= 1'b0;
      r_sync_s    <= 1'b0;
      r_sync_d    <= 1'b0;
      r_sync_rise <= 1'b0;
    end else begin
      r_sync_meta <= tdd_sync_i;
      r_sync_s    <= r_sync_meta;
      r_sync_d    <= r_sync_s;
      r_sync_rise <= r_sync_s & ~r_sync_d;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= S_IDLE;
      r_cfg_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!tdd_enable)
        r_cfg_error <= 1'b0;
      else if (r_state == S_IDLE && !r_cfg_error && w_cfg_bad)
        r_cfg_error <= 1'b1;
    end
  end

  // Shadow copy taken on arming; the live inputs are ignored until the next arm.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_len    <= '0;
      r_rx_on  <= '0;
      r_rx_off <= '0;
      r_tx_on  <= '0;
      r_tx_off <= '0;
      r_burst  <= '0;
      r_slave  <= 1'b0;
    end else if (w_capture) begin
      r_len    <= frame_length;
      r_rx_on  <= rx_on;
      r_rx_off <= rx_off;
      r_tx_on  <= tx_on;
      r_tx_off <= tx_off;
      r_burst  <= burst_frames;
      r_slave  <= sync_slave;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_cnt     <= '0;
      r_frames  <= '0;
      r_arm_cnt <= '0;
      r_first   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_frames  <= '0;
          r_arm_cnt <= '0;
          r_first   <= 1'b1;
        end
        S_ARM: begin
          r_cnt     <= '0;
          r_arm_cnt <= r_arm_cnt + AW'(1);
        end
        S_RUN: begin
          if (w_last) begin
            r_cnt    <= '0;
            r_frames <= r_frames + 8'd1;
            r_first  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // enable is zeroed on the edge into DRAIN so the drain cycle never drives the chips.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_enable <= 1'b0;
      r_txnrx  <= 1'b0;
    end else begin
      r_enable <= (r_state == S_RUN) && (w_state_next == S_RUN) && (w_rx_act || w_tx_act);
      if (r_state == S_RUN) begin
        if (w_tx_act)      r_txnrx <= 1'b1;
        else if (w_rx_act) r_txnrx <= 1'b0;
      end
    end
  end

  // The ARM pulse marks the first frame, so the in-run pulse starts from the second frame.
  assign w_master_drive = !r_slave && ((r_state == S_ARM) || (r_state == S_RUN));
  assign tdd_sync_t     = !w_master_drive;
  assign tdd_sync_o     = !r_slave &&
                          ((r_state == S_ARM) ||
                           ((r_state == S_RUN) && !r_first && (r_cnt < PULSE_LEN)));

  assign enable      = r_enable;
  assign txnrx       = r_txnrx;
  assign frame_count = r_cnt;
  assign frame_done  = (r_state == S_RUN) && w_last;
  assign busy        = (r_state != S_IDLE);
  assign cfg_error   = r_cfg_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ad9361x2_tdd_sequencer.sv
// Bench for ad9361x2_tdd_sequencer: directed scenarios plus randomized runs, each checked
// cycle by cycle against a frame-arithmetic model of the scheduler.
module tb_ad9361x2_tdd_sequencer;

  localparam int CW = 24;
  localparam int P  = 4;

  logic          clk;
  logic          axi_aresetn;
  logic          tdd_enable;
  logic          sync_slave;
  logic [CW-1:0] frame_length;
  logic [CW-1:0] rx_on;
  logic [CW-1:0] rx_off;
  logic [CW-1:0] tx_on;
  logic [CW-1:0] tx_off;
  logic [7:0]    burst_frames;
  logic          tdd_sync_i;
  logic          tdd_sync_o;
  logic          tdd_sync_t;
  logic          enable;
  logic          txnrx;
  logic [CW-1:0] frame_count;
  logic          frame_done;
  logic          busy;
  logic          cfg_error;
  logic [1:0]    dbg_state;

  int   tests;
  int   fails;
  logic m_tx;

  ad9361x2_tdd_sequencer #(.CNT_WIDTH(CW), .SYNC_PULSE_CYCLES(P)) dut (
    .axi_aclk     (clk),
    .axi_aresetn  (axi_aresetn),
    .tdd_enable   (tdd_enable),
    .sync_slave   (sync_slave),
    .frame_length (frame_length),
    .rx_on        (rx_on),
    .rx_off       (rx_off),
    .tx_on        (tx_on),
    .tx_off       (tx_off),
    .burst_frames (burst_frames),
    .tdd_sync_i   (tdd_sync_i),
    .tdd_sync_o   (tdd_sync_o),
    .tdd_sync_t   (tdd_sync_t),
    .enable       (enable),
    .txnrx        (txnrx),
    .frame_count  (frame_count),
    .frame_done   (frame_done),
    .busy         (busy),
    .cfg_error    (cfg_error),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string ph, input int b, input int cnt, input int fd,
                            input int en, input int tx, input int so, input int st,
                            input int ce);
    chk({ph, ".busy"},        32'(busy),        b);
    chk({ph, ".frame_count"}, 32'(frame_count), cnt);
    chk({ph, ".frame_done"},  32'(frame_done),  fd);
    chk({ph, ".enable"},      32'(enable),      en);
    chk({ph, ".txnrx"},       32'(txnrx),       tx);
    chk({ph, ".sync_o"},      32'(tdd_sync_o),  so);
    chk({ph, ".sync_t"},      32'(tdd_sync_t),  st);
    chk({ph, ".cfg_error"},   32'(cfg_error),   ce);
  endtask

  function automatic bit in_win(input int on_c, input int off_c, input int c);
    if (on_c < off_c) return (c >= on_c) && (c < off_c);
    if (on_c > off_c) return (c >= on_c) || (c < off_c);
    return 1'b0;
  endfunction

  task automatic set_cfg(input int l, input int ron, input int roff, input int ton,
                         input int toff, input int bf, input bit sl);
    frame_length = CW'(l);
    rx_on        = CW'(ron);
    rx_off       = CW'(roff);
    tx_on        = CW'(ton);
    tx_off       = CW'(toff);
    burst_frames = 8'(bf);
    sync_slave   = sl;
  endtask

  task automatic scramble();
    frame_length = CW'($urandom);
    rx_on        = CW'($urandom);
    rx_off       = CW'($urandom);
    tx_on        = CW'($urandom);
    tx_off       = CW'($urandom);
    burst_frames = 8'($urandom);
    sync_slave   = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outs("idle", 0, 0, 0, 0, int'(m_tx), 0, 1, 0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_seq(input int l, input int ron, input int roff, input int ton,
                         input int toff, input int bf, input bit sl, input int drop_frame,
                         input int drop_cnt, input int rst_cnt);
    int  frames;
    int  total;
    int  c;
    int  pc;
    int  en_exp;
    int  so_exp;
    int  wait_n;
    bit  a_rx;
    bit  a_tx;
    set_cfg(l, ron, roff, ton, toff, bf, sl);
    tdd_enable = 1'b1;
    @(negedge clk);
    if (!sl) begin
      for (int j = 0; j < P; j++) begin
        check_outs("arm_m", 1, 0, 0, 0, int'(m_tx), 1, 0, 0);
        scramble();
        @(negedge clk);
      end
    end else begin
      wait_n = $urandom_range(1, 5);
      for (int j = 0; j < wait_n; j++) begin
        check_outs("arm_s", 1, 0, 0, 0, int'(m_tx), 0, 1, 0);
        scramble();
        if (j == wait_n - 1) tdd_sync_i = 1'b1;
        @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
        check_outs("arm_s_sync", 1, 0, 0, 0, int'(m_tx), 0, 1, 0);
        @(negedge clk);
      end
    end
    if (bf != 0 && (drop_frame < 0 || bf <= drop_frame)) frames = bf;
    else if (drop_frame >= 0)                            frames = drop_frame + 1;
    else                                                 frames = 1;
    total = frames * (l + 1);
    for (int k = 0; k < total; k++) begin
      c      = k % (l + 1);
      en_exp = 0;
      if (k > 0) begin
        pc   = (k - 1) % (l + 1);
        a_rx = in_win(ron, roff, pc);
        a_tx = in_win(ton, toff, pc);
        en_exp = int'(a_rx | a_tx);
        if (a_tx)      m_tx = 1'b1;
        else if (a_rx) m_tx = 1'b0;
      end
      so_exp = int'(!sl && k >= l + 1 && c < P);
      check_outs("run", 1, c, int'(c == l), en_exp, int'(m_tx), so_exp, int'(sl), 0);
      if (k == rst_cnt) begin
        axi_aresetn = 1'b0;
        tdd_enable  = 1'b0;
        tdd_sync_i  = 1'b0;
        #1;
        m_tx = 1'b0;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        axi_aresetn = 1'b1;
        return;
      end
      scramble();
      if (sl) tdd_sync_i = 1'($urandom_range(0, 1));
      if (k / (l + 1) == drop_frame && c == drop_cnt) tdd_enable = 1'b0;
      @(negedge clk);
    end
    a_rx = in_win(ron, roff, l);
    a_tx = in_win(ton, toff, l);
    if (a_tx)      m_tx = 1'b1;
    else if (a_rx) m_tx = 1'b0;
    check_outs("drain", 1, 0, 0, 0, int'(m_tx), 0, 1, 0);
    @(negedge clk);
    check_outs("back_idle", 0, 0, 0, 0, int'(m_tx), 0, 1, 0);
    tdd_enable = 1'b0;
    tdd_sync_i = 1'b0;
  endtask

  task automatic cfg_err_case(input int l, input int ron, input int roff, input int ton,
                              input int toff);
    set_cfg(l, ron, roff, ton, toff, 1, 1'b0);
    tdd_enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_outs("cfg_err", 0, 0, 0, 0, int'(m_tx), 0, 1, 1);
    end
    tdd_enable = 1'b0;
    @(negedge clk);
    check_outs("cfg_clear", 0, 0, 0, 0, int'(m_tx), 0, 1, 0);
  endtask

  initial begin
    int l;
    int bf;
    int df;
    tests        = 0;
    fails        = 0;
    m_tx         = 1'b0;
    axi_aresetn  = 1'b1;
    tdd_enable   = 1'b0;
    tdd_sync_i   = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
    #2 axi_aresetn = 1'b0;
    #2 check_outs("reset", 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    axi_aresetn = 1'b1;
    idle(3);

    run_seq(99, 10, 40, 50, 90, 2, 1'b0, -1, 0, -1);
    idle(3);
    run_seq(49, 5, 30, 35, 45, 1, 1'b1, -1, 0, -1);
    idle(3);
    run_seq(99, 20, 20, 90, 5, 1, 1'b0, -1, 0, -1);
    idle(3);
    cfg_err_case(99, 10, 40, 150, 90);
    cfg_err_case(99, 10, 100, 50, 90);
    idle(2);
    run_seq(99, 10, 40, 50, 90, 0, 1'b0, 1, 30, -1);
    idle(3);
    run_seq(99, 10, 40, 50, 90, 0, 1'b0, -1, 0, 45);
    idle(4);
    run_seq(0, 0, 0, 0, 0, 3, 1'b0, -1, 0, -1);
    idle(3);
    run_seq(0, 0, 0, 0, 0, 2, 1'b1, -1, 0, -1);
    idle(3);

    set_cfg(20, 1, 5, 6, 9, 1, 1'b0);
    tdd_enable = 1'b1;
    @(negedge clk);
    check_outs("abort_arm", 1, 0, 0, 0, int'(m_tx), 1, 0, 0);
    tdd_enable = 1'b0;
    @(negedge clk);
    check_outs("abort_idle", 0, 0, 0, 0, int'(m_tx), 0, 1, 0);
    idle(3);

    for (int r = 0; r < 10; r++) begin
      l  = $urandom_range(0, 40);
      bf = $urandom_range(0, 3);
      df = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
      if (bf == 0 && df < 0) df = 1;
      run_seq(l, $urandom_range(0, l), $urandom_range(0, l), $urandom_range(0, l),
              $urandom_range(0, l), bf, 1'($urandom_range(0, 1)), df,
              $urandom_range(0, l), -1);
      idle(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
